// File: rtl/temp_avg_from_fifo.sv
// rtl/temp_avg_from_fifo.sv - pops temperature bytes from the sync FIFO and emits the truncated mean of each group
module temp_avg_from_fifo #(
  parameter int DATA_W    = 8,
  parameter int LOG2_N    = 2,
  parameter int N_SAMPLES = 4
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              rd_fifo,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic [LOG2_N-1:0] sample_cnt,
  output logic              busy
);

  // Accumulator is wide enough for N_SAMPLES full-scale bytes, so it never overflows.
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             last_sample;

  // Running sum including the word that arrives in LATCH.
  assign sum         = acc + ACC_W'(fifo_data);
  assign last_sample = (sample_cnt == CNT_LAST);

  // State register; reset abandons any read or group in flight.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one pop per pass, only ever launched from IDLE on a non-empty FIFO.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = READ;
      READ:    state_nxt = LATCH;
      LATCH:   state_nxt = last_sample ? DONE : IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    rd_fifo   = (state == READ);
    avg_valid = (state == DONE);
    busy      = (state != IDLE) || (sample_cnt != '0);
  end

  // Datapath: accumulate in LATCH, publish the mean and clear on the last sample of a group.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      sample_cnt <= '0;
      avg_out    <= '0;
    end else if (state == LATCH) begin
      if (last_sample) begin
        avg_out    <= sum[ACC_W-1:LOG2_N];
        acc        <= '0;
        sample_cnt <= '0;
      end else begin
        acc        <= sum;
        sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

endmodule
